// File: rtl/gate_equiv_sequencer.sv
// Exhaustive truth-table sweep sequencer comparing two gate networks driven by one stimulus.
// Reports the mismatch count, the first failing vector and a pass verdict per sweep.
module gate_equiv_sequencer #(
  parameter int N_INPUTS      = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                resp_x,
  input  logic                resp_y,
  output logic [N_INPUTS-1:0] stim,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   mismatch_count,
  output logic [N_INPUTS-1:0] first_fail_vec,
  output logic                first_fail_valid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    APPLY   = 3'd1,
    SETTLE  = 3'd2,
    COMPARE = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [N_INPUTS-1:0] LAST_VEC    = '1;
  localparam logic [3:0]          SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  state_e              state_q;
  logic [3:0]          settle_q;
  logic [N_INPUTS-1:0] stim_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [N_INPUTS:0]   count_q;
  logic [N_INPUTS-1:0] ffvec_q;
  logic                ffvalid_q;
  logic                resp_diff;
  logic                accept;

  assign resp_diff = resp_x ^ resp_y;
  // DONE also accepts start so a held start yields back-to-back sweeps with no idle gap.
  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      settle_q  <= 4'd0;
      stim_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      count_q   <= '0;
      ffvec_q   <= '0;
      ffvalid_q <= 1'b0;
    end else if (accept) begin
      state_q   <= APPLY;
      stim_q    <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      count_q   <= '0;
      ffvec_q   <= '0;
      ffvalid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: ;
        APPLY: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (SETTLE_CYCLES > 0) begin
            state_q  <= SETTLE;
            settle_q <= SETTLE_LOAD;
          end else begin
            state_q <= COMPARE;
          end
        end
        SETTLE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (settle_q == 4'd0) begin
            state_q <= COMPARE;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        COMPARE: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            if (resp_diff) begin
              count_q <= count_q + 1'b1;
              if (!ffvalid_q) begin
                ffvec_q   <= stim_q;
                ffvalid_q <= 1'b1;
              end
            end
            // Verdict includes this final comparison, so it is valid alongside done.
            if (stim_q == LAST_VEC) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              pass_q  <= (count_q == '0) && !resp_diff;
            end else begin
              stim_q  <= stim_q + 1'b1;
              state_q <= APPLY;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign mismatch_count   = count_q;
  assign first_fail_vec   = ffvec_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_gate_equiv_sequencer.sv
// Randomized bench for gate_equiv_sequencer: three instances (settle 1, 0, 3) checked
// against a truth-table reference model of the sweep results and its timing.
module tb_gate_equiv_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n;
  logic [2:0] start_w, abort_w, rx_w, ry_w, busy_w, done_w, pass_w, ffval_w;
  logic [1:0] stim_w [3];
  logic [2:0] cnt_w  [3];
  logic [1:0] ffv_w  [3];
  logic [3:0] tt_x   [3];
  logic [3:0] tt_y   [3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  // Reference model: results follow directly from the two truth tables.
  function automatic int exp_count(input logic [3:0] x, input logic [3:0] y);
    int n = 0;
    for (int v = 0; v < 4; v++) if (x[v] != y[v]) n++;
    return n;
  endfunction

  function automatic int exp_first(input logic [3:0] x, input logic [3:0] y);
    for (int v = 0; v < 4; v++) if (x[v] != y[v]) return v;
    return 0;
  endfunction

  always_comb begin
    rx_w = '0;
    ry_w = '0;
    for (int i = 0; i < 3; i++) begin
      rx_w[i] = tt_x[i][stim_w[i]];
      ry_w[i] = tt_y[i][stim_w[i]];
    end
  end

  gate_equiv_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_w[0]), .abort(abort_w[0]),
    .resp_x(rx_w[0]), .resp_y(ry_w[0]), .stim(stim_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .pass(pass_w[0]), .mismatch_count(cnt_w[0]),
    .first_fail_vec(ffv_w[0]), .first_fail_valid(ffval_w[0]));

  gate_equiv_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_w[1]), .abort(abort_w[1]),
    .resp_x(rx_w[1]), .resp_y(ry_w[1]), .stim(stim_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .pass(pass_w[1]), .mismatch_count(cnt_w[1]),
    .first_fail_vec(ffv_w[1]), .first_fail_valid(ffval_w[1]));

  gate_equiv_sequencer #(.N_INPUTS(2), .SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_w[2]), .abort(abort_w[2]),
    .resp_x(rx_w[2]), .resp_y(ry_w[2]), .stim(stim_w[2]), .busy(busy_w[2]),
    .done(done_w[2]), .pass(pass_w[2]), .mismatch_count(cnt_w[2]),
    .first_fail_vec(ffv_w[2]), .first_fail_valid(ffval_w[2]));

  // Monitor: expected stimulus is vector (k / (settle+2)) for the k-th sweeping cycle.
  int   pos       [3] = '{0, 0, 0};
  int   seq_err   [3] = '{0, 0, 0};
  int   done_cnt  [3] = '{0, 0, 0};
  int   done_cyc  [3] = '{0, 0, 0};
  logic [2:0] prev_busy = '0;
  int   done_t0 [$];

  always @(negedge clk) begin
    int exp_s;
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_w[i] && !done_w[i]) begin
          if (!prev_busy[i]) begin
            exp_s = 0;
            pos[i] <= 1;
          end else begin
            exp_s = (pos[i] / (settle_of(i) + 2)) % 4;
            pos[i] <= pos[i] + 1;
          end
          if (int'(stim_w[i]) != exp_s) seq_err[i] <= seq_err[i] + 1;
        end
        if (done_w[i]) begin
          done_cnt[i] <= done_cnt[i] + 1;
          done_cyc[i] <= cyc;
          if (i == 0) done_t0.push_back(cyc);
          chk($sformatf("u%0d_count", i), int'(cnt_w[i]), exp_count(tt_x[i], tt_y[i]));
          chk($sformatf("u%0d_pass", i), int'(pass_w[i]), int'(exp_count(tt_x[i], tt_y[i]) == 0));
          chk($sformatf("u%0d_ffvalid", i), int'(ffval_w[i]), int'(exp_count(tt_x[i], tt_y[i]) != 0));
          chk($sformatf("u%0d_ffvec", i), int'(ffv_w[i]), exp_first(tt_x[i], tt_y[i]));
        end
        prev_busy[i] <= busy_w[i];
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_stim"},    int'(stim_w[0]),  0);
    chk({tag, "_busy"},    int'(busy_w[0]),  0);
    chk({tag, "_done"},    int'(done_w[0]),  0);
    chk({tag, "_pass"},    int'(pass_w[0]),  0);
    chk({tag, "_count"},   int'(cnt_w[0]),   0);
    chk({tag, "_ffvec"},   int'(ffv_w[0]),   0);
    chk({tag, "_ffvalid"}, int'(ffval_w[0]), 0);
  endtask

  task automatic run_sweep(input logic [2:0] mask);
    int a;
    int d0 [3];
    int e0 [3];
    bit all_done;
    for (int i = 0; i < 3; i++) begin
      d0[i] = done_cnt[i];
      e0[i] = seq_err[i];
    end
    start_w = mask;
    a = cyc + 1;
    step();
    start_w = '0;
    for (int k = 0; k < 60; k++) begin
      all_done = 1'b1;
      for (int i = 0; i < 3; i++) if (mask[i] && done_cnt[i] == d0[i]) all_done = 1'b0;
      if (all_done) break;
      step();
    end
    step();
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        chk($sformatf("u%0d_done_pulses", i), done_cnt[i] - d0[i], 1);
        chk($sformatf("u%0d_latency", i), done_cyc[i] - a, 4 * (settle_of(i) + 2));
        chk($sformatf("u%0d_stim_seq", i), seq_err[i] - e0[i], 0);
        chk($sformatf("u%0d_pass_held", i), int'(pass_w[i]), int'(exp_count(tt_x[i], tt_y[i]) == 0));
        chk($sformatf("u%0d_idle_stim", i), int'(stim_w[i]), 3);
        chk($sformatf("u%0d_idle_busy", i), int'(busy_w[i]), 0);
      end
    end
  endtask

  initial begin
    int a;
    int d;
    int n;
    rst_n   = 1'b0;
    start_w = '0;
    abort_w = '0;
    for (int i = 0; i < 3; i++) begin
      tt_x[i] = 4'b0111;
      tt_y[i] = 4'b0111;
    end
    step();
    step();
    chk_zero0("reset");
    rst_n = 1'b1;
    step();

    // NAND vs negative-OR: equivalent.
    run_sweep(3'b111);
    // NAND vs NOR: mismatches at 01 and 10.
    for (int i = 0; i < 3; i++) tt_y[i] = 4'b0001;
    run_sweep(3'b111);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) begin
        tt_x[i] = 4'($urandom_range(0, 15));
        tt_y[i] = ($urandom_range(0, 2) == 0) ? tt_x[i] : 4'($urandom_range(0, 15));
      end
      run_sweep(3'b111);
    end

    // Start held high: back-to-back sweeps, one done every 13 cycles.
    tt_x[0] = 4'b0111;
    tt_y[0] = 4'b0001;
    d = done_cnt[0];
    start_w[0] = 1'b1;
    repeat (30) step();
    start_w[0] = 1'b0;
    for (int k = 0; k < 60 && busy_w[0]; k++) step();
    chk("held_idle", int'(busy_w[0]), 0);
    chk("held_dones", done_cnt[0] - d, 3);
    n = done_t0.size();
    if (n >= 3) begin
      chk("held_gap1", done_t0[n-2] - done_t0[n-3], 13);
      chk("held_gap2", done_t0[n-1] - done_t0[n-2], 13);
    end else begin
      chk("held_done_log", n, 3);
    end

    // Abort while vector 2 is settling.
    start_w[0] = 1'b1;
    a = cyc + 1;
    step();
    start_w[0] = 1'b0;
    for (int k = 0; k < 40 && cyc < a + 7; k++) step();
    chk("abort_pre_stim", int'(stim_w[0]), 2);
    chk("abort_pre_busy", int'(busy_w[0]), 1);
    abort_w[0] = 1'b1;
    d = done_cnt[0];
    step();
    abort_w[0] = 1'b0;
    chk("abort_busy", int'(busy_w[0]), 0);
    chk("abort_stim", int'(stim_w[0]), 2);
    chk("abort_pass", int'(pass_w[0]), 0);
    chk("abort_done", int'(done_w[0]), 0);
    chk("abort_count", int'(cnt_w[0]), 1);
    chk("abort_ffvalid", int'(ffval_w[0]), 1);
    chk("abort_ffvec", int'(ffv_w[0]), 1);
    repeat (15) step();
    chk("abort_no_done", done_cnt[0] - d, 0);

    // Start and abort together in IDLE: start wins.
    start_w[0] = 1'b1;
    abort_w[0] = 1'b1;
    step();
    start_w[0] = 1'b0;
    abort_w[0] = 1'b0;
    chk("start_over_abort", int'(busy_w[0]), 1);
    for (int k = 0; k < 40 && busy_w[0]; k++) step();
    chk("start_over_abort_done", done_cnt[0] - d, 1);

    // Reset mid-COMPARE of vector 1.
    start_w[0] = 1'b1;
    a = cyc + 1;
    step();
    start_w[0] = 1'b0;
    for (int k = 0; k < 40 && cyc < a + 5; k++) step();
    d = done_cnt[0];
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_zero0("midreset");
    repeat (15) step();
    chk("midreset_no_done", done_cnt[0] - d, 0);
    tt_y[0] = 4'b0111;
    run_sweep(3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
